// File: rtl/timer_bank_if.sv
// Register bus, tick inputs and timer outputs of timer_bank, grouped so the bank and its
// driver share one parameterised bundle.
interface timer_bank_if #(
    parameter int CH_BITS = 2
) ();
    localparam int CHANNELS = 2 ** CH_BITS;

    logic [CHANNELS-1:0] tick_en;
    logic                we;
    logic [CH_BITS+1:0]  addr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic [CHANNELS-1:0] cnt_out;
    logic                irq;

    modport master (
        output tick_en, we, addr, wdata,
        input  rdata, cnt_out, irq
    );

    modport slave (
        input  tick_en, we, addr, wdata,
        output rdata, cnt_out, irq
    );
endinterface

// File: rtl/timer_bank.sv
// Bank of 2**CH_BITS down-counting timers (stop/one-shot/periodic/square) behind a small register file.
// Define TIMER_BANK_IRQ_EN to add per-channel pending status, irq enable and the irq output.
module timer_bank #(
    parameter int CH_BITS = 2,
    parameter int WIDTH   = 32
) (
    input logic         clk,
    input logic         rst,
    timer_bank_if.slave bus
);
    localparam int CHANNELS = 2 ** CH_BITS;

    typedef enum logic [1:0] {
        MODE_STOP     = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_SQUARE   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        REG_LOAD   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_COUNT  = 2'd2,
        REG_STATUS = 2'd3
    } reg_e;

    logic [WIDTH-1:0]    load_q  [CHANNELS];
    logic [WIDTH-1:0]    load_d  [CHANNELS];
    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    mode_e               mode_q  [CHANNELS];
    mode_e               mode_d  [CHANNELS];
    logic [CHANNELS-1:0] cntOut_q, cntOut_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [CH_BITS-1:0]  addrCh;
    reg_e                addrReg;
    logic [CHANNELS-1:0] loadWr, ctrlWr, tickRun, terminal;
    logic                unusedBits;

    assign addrCh     = bus.addr[CH_BITS+1:2];
    assign addrReg    = reg_e'(bus.addr[1:0]);
    assign unusedBits = ^bus.wdata;

    // A CTRL write to a channel swallows any tick arriving in the same cycle.
    always_comb begin
        loadWr   = '0;
        ctrlWr   = '0;
        tickRun  = '0;
        terminal = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            loadWr[ch]   = bus.we && (addrCh == CH_BITS'(ch)) && (addrReg == REG_LOAD);
            ctrlWr[ch]   = bus.we && (addrCh == CH_BITS'(ch)) && (addrReg == REG_CTRL);
            tickRun[ch]  = bus.tick_en[ch] && (mode_q[ch] != MODE_STOP) && !ctrlWr[ch];
            terminal[ch] = tickRun[ch] && (count_q[ch] <= WIDTH'(1));
        end
    end

    always_comb begin
        cntOut_d = cntOut_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            load_d[ch]  = loadWr[ch] ? bus.wdata[WIDTH-1:0] : load_q[ch];
            count_d[ch] = count_q[ch];
            mode_d[ch]  = mode_q[ch];
            if (mode_q[ch] == MODE_PERIODIC) begin
                cntOut_d[ch] = 1'b0;
            end
            if (ctrlWr[ch]) begin
                mode_d[ch] = mode_e'(bus.wdata[1:0]);
                if (bus.wdata[1:0] != 2'b00) begin
                    count_d[ch]  = load_q[ch];
                    cntOut_d[ch] = 1'b0;
                end
            end else if (terminal[ch]) begin
                case (mode_q[ch])
                    MODE_ONESHOT: begin
                        count_d[ch]  = '0;
                        cntOut_d[ch] = 1'b1;
                        mode_d[ch]   = MODE_STOP;
                    end
                    MODE_PERIODIC: begin
                        count_d[ch]  = load_q[ch];
                        cntOut_d[ch] = 1'b1;
                    end
                    MODE_SQUARE: begin
                        count_d[ch]  = load_q[ch];
                        cntOut_d[ch] = ~cntOut_q[ch];
                    end
                    default: ;
                endcase
            end else if (tickRun[ch]) begin
                count_d[ch] = count_q[ch] - WIDTH'(1);
            end
        end
    end

`ifdef TIMER_BANK_IRQ_EN
    logic [CHANNELS-1:0] irqEn_q, irqEn_d, pending_q, pending_d, statusClr;

    // A terminal event outranks a simultaneous STATUS clear so no event is ever lost.
    always_comb begin
        statusClr = '0;
        irqEn_d   = irqEn_q;
        pending_d = pending_q;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            statusClr[ch] = bus.we && (addrCh == CH_BITS'(ch)) && (addrReg == REG_STATUS) && bus.wdata[0];
            if (ctrlWr[ch]) begin
                irqEn_d[ch] = bus.wdata[2];
            end
            if (terminal[ch]) begin
                pending_d[ch] = 1'b1;
            end else if (statusClr[ch]) begin
                pending_d[ch] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            irqEn_q   <= '0;
            pending_q <= '0;
        end else begin
            irqEn_q   <= irqEn_d;
            pending_q <= pending_d;
        end
    end

    assign bus.irq = |(pending_q & irqEn_q);
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        rdata_d = '0;
        case (addrReg)
            REG_LOAD:  rdata_d[WIDTH-1:0] = load_q[addrCh];
            REG_CTRL: begin
                rdata_d[1:0] = mode_q[addrCh];
`ifdef TIMER_BANK_IRQ_EN
                rdata_d[2]   = irqEn_q[addrCh];
`endif
            end
            REG_COUNT: rdata_d[WIDTH-1:0] = count_q[addrCh];
            REG_STATUS: begin
`ifdef TIMER_BANK_IRQ_EN
                rdata_d[0] = pending_q[addrCh];
`else
                rdata_d = '0;
`endif
            end
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                load_q[ch]  <= '0;
                count_q[ch] <= '0;
                mode_q[ch]  <= MODE_STOP;
            end
            cntOut_q <= '0;
            rdata_q  <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                load_q[ch]  <= load_d[ch];
                count_q[ch] <= count_d[ch];
                mode_q[ch]  <= mode_d[ch];
            end
            cntOut_q <= cntOut_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rdata   = rdata_q;
    assign bus.cnt_out = cntOut_q;
endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: a vector table for the one-shot/periodic/priority behaviour,
// plus hand-written sequences for square wave, interrupts, mid-count reset and a narrow 8-channel build.
module tb_timer_bank;
`ifdef TIMER_BANK_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    timer_bank_if #(.CH_BITS(2)) bus ();
    timer_bank_if #(.CH_BITS(3)) bus8 ();

    timer_bank #(.CH_BITS(2), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    timer_bank #(.CH_BITS(3), .WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstN;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  tick;
        logic [31:0] expRdata;
        logic [3:0]  expCnt;
        logic        expIrq;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic rstN, input logic we, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [3:0] tick,
                          input logic [31:0] expRdata, input logic [3:0] expCnt, input logic expIrq);
        vec_t v;
        v.rstN = rstN; v.we = we; v.addr = addr; v.wdata = wdata; v.tick = tick;
        v.expRdata = expRdata; v.expCnt = expCnt; v.expIrq = expIrq;
        vecs.push_back(v);
    endtask

    // Drives one cycle of inputs and returns 1 time unit after the edge that consumed them.
    task automatic applyStimulus(input logic rstV, input logic weV, input logic [3:0] addrV,
                                 input logic [31:0] wdataV, input logic [3:0] tickV);
        rst         = rstV;
        bus.we      = weV;
        bus.addr    = addrV;
        bus.wdata   = wdataV;
        bus.tick_en = tickV;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        bus.we       = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.tick_en  = '0;
        bus8.we      = 1'b0;
        bus8.addr    = '0;
        bus8.wdata   = '0;
        bus8.tick_en = '0;
        repeat (2) @(posedge clk);
        #1;

        // rstN, we, addr, wdata, tick | rdata, cnt_out, irq
        addVec(0, 0, 4'd0, 32'd0, 4'b0000,  32'd0, 4'b0000, 0);
        addVec(1, 1, 4'd0, 32'd3, 4'b0000,  32'd0, 4'b0000, 0);
        addVec(1, 1, 4'd1, 32'd1, 4'b0000,  32'd0, 4'b0000, 0);
        addVec(1, 0, 4'd2, 32'd0, 4'b0001,  32'd3, 4'b0000, 0);
        addVec(1, 0, 4'd2, 32'd0, 4'b0001,  32'd2, 4'b0000, 0);
        addVec(1, 0, 4'd2, 32'd0, 4'b0001,  32'd1, 4'b0001, 0);
        addVec(1, 0, 4'd2, 32'd0, 4'b0000,  32'd0, 4'b0001, 0);
        addVec(1, 0, 4'd1, 32'd0, 4'b0001,  32'd0, 4'b0001, 0);
        addVec(1, 0, 4'd2, 32'd0, 4'b0001,  32'd0, 4'b0001, 0);
        addVec(1, 0, 4'd0, 32'd0, 4'b0000,  32'd3, 4'b0001, 0);
        addVec(1, 1, 4'd4, 32'd4, 4'b0000,  32'd0, 4'b0001, 0);
        addVec(1, 1, 4'd5, 32'd2, 4'b0000,  32'd0, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd4, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd3, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd2, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd1, 4'b0011, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd4, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd3, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd2, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd1, 4'b0011, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0000,  32'd4, 4'b0001, 0);
        addVec(1, 1, 4'd4, 32'd2, 4'b0010,  32'd4, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd3, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd2, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd1, 4'b0011, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0010,  32'd2, 4'b0001, 0);
        addVec(1, 1, 4'd5, 32'd2, 4'b0010,  32'd2, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0000,  32'd2, 4'b0001, 0);
        addVec(1, 1, 4'd6, 32'd9, 4'b0000,  32'd2, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b0000,  32'd2, 4'b0001, 0);
        addVec(1, 1, 4'd5, 32'd0, 4'b0000,  32'd2, 4'b0001, 0);
        addVec(1, 0, 4'd6, 32'd0, 4'b1111,  32'd2, 4'b0001, 0);
        addVec(0, 1, 4'd0, 32'd5, 4'b1111,  32'd0, 4'b0000, 0);
        addVec(1, 0, 4'd0, 32'd0, 4'b0000,  32'd0, 4'b0000, 0);
        addVec(1, 0, 4'd4, 32'd0, 4'b0000,  32'd0, 4'b0000, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rstN, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].tick);
            checkOutput($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].expRdata);
            checkOutput($sformatf("vec%0d cnt_out", i), {28'd0, bus.cnt_out}, {28'd0, vecs[i].expCnt});
            checkOutput($sformatf("vec%0d irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].expIrq});
        end

        // Square wave on channel 3: LOAD=2, one tick every 5 cycles, toggles 5 cycles after the first tick then every 10.
        applyStimulus(1, 1, 4'd12, 32'd2, 4'b0000);
        applyStimulus(1, 1, 4'd13, 32'd3, 4'b0000);
        checkOutput("square start", {31'd0, bus.cnt_out[3]}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1, 0, 4'd0, 32'd0, (k % 5 == 0) ? 4'b1000 : 4'b0000);
            checkOutput($sformatf("square k%0d", k), {31'd0, bus.cnt_out[3]}, 32'(((k + 5) / 10) % 2));
        end

        // Interrupt on channel 2: periodic with irq_en, LOAD=1; a clear coinciding with an event must not win.
        applyStimulus(1, 1, 4'd8, 32'd1, 4'b0000);
        applyStimulus(1, 1, 4'd9, 32'd6, 4'b0000);
        checkOutput("irq before tick", {31'd0, bus.irq}, 32'd0);
        applyStimulus(1, 0, 4'd11, 32'd0, 4'b0100);
        checkOutput("irq after tick", {31'd0, bus.irq}, {31'd0, IRQ_ON});
        checkOutput("status before tick", bus.rdata, 32'd0);
        applyStimulus(1, 1, 4'd11, 32'd1, 4'b0100);
        checkOutput("irq clear vs event", {31'd0, bus.irq}, {31'd0, IRQ_ON});
        checkOutput("status pending read", bus.rdata, {31'd0, IRQ_ON});
        applyStimulus(1, 1, 4'd11, 32'd1, 4'b0000);
        checkOutput("irq cleared", {31'd0, bus.irq}, 32'd0);
        applyStimulus(1, 0, 4'd11, 32'd0, 4'b0000);
        checkOutput("status after clear", bus.rdata, 32'd0);
        applyStimulus(1, 0, 4'd9, 32'd0, 4'b0000);
        checkOutput("ctrl ch2 read", bus.rdata, IRQ_ON ? 32'd6 : 32'd2);

        // Channel 2 held at COUNT=7 and then reset mid-count, with a write and ticks ignored during reset.
        applyStimulus(1, 1, 4'd8, 32'd7, 4'b0000);
        applyStimulus(1, 1, 4'd9, 32'd6, 4'b0000);
        applyStimulus(1, 1, 4'd11, 32'd0, 4'b0100);
        applyStimulus(1, 0, 4'd10, 32'd0, 4'b0000);
        checkOutput("count ch2 before reset", bus.rdata, 32'd6);
        applyStimulus(0, 1, 4'd8, 32'd5, 4'b0100);
        checkOutput("reset cnt_out", {28'd0, bus.cnt_out}, 32'd0);
        checkOutput("reset irq", {31'd0, bus.irq}, 32'd0);
        checkOutput("reset rdata", bus.rdata, 32'd0);
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1, 0, 4'(8 + r), 32'd0, 4'b0100);
            checkOutput($sformatf("ch2 reg%0d after reset", r), bus.rdata, 32'd0);
            checkOutput($sformatf("irq after reset %0d", r), {31'd0, bus.irq}, 32'd0);
        end
        checkOutput("cnt_out after reset ticks", {28'd0, bus.cnt_out}, 32'd0);

        // Narrow 8-channel instance: LOAD keeps only WIDTH bits and other channels stay untouched.
        bus8.we    = 1'b1;
        bus8.addr  = 5'd28;
        bus8.wdata = 32'h1FF;
        applyStimulus(1, 0, 4'd0, 32'd0, 4'b0000);
        bus8.we    = 1'b0;
        bus8.wdata = '0;
        applyStimulus(1, 0, 4'd0, 32'd0, 4'b0000);
        checkOutput("w8 ch7 load", bus8.rdata, 32'hFF);
        for (int ch = 0; ch < 7; ch++) begin
            bus8.addr = {3'(ch), 2'b00};
            applyStimulus(1, 0, 4'd0, 32'd0, 4'b0000);
            checkOutput($sformatf("w8 ch%0d load", ch), bus8.rdata, 32'd0);
        end
        bus8.addr = 5'd30;
        applyStimulus(1, 0, 4'd0, 32'd0, 4'b0000);
        checkOutput("w8 ch7 count", bus8.rdata, 32'd0);
        checkOutput("w8 cnt_out", {24'd0, bus8.cnt_out}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter CH_BITS, default 2, channel-index width; channel count CHANNELS = 2**CH_BITS.
REQ-002 Parameter WIDTH, default 32, counter width, legal range 2..32.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 tick_en  input  CHANNELS  per-channel count enable, one-cycle pulses from the clkdiv-derived prescaler.
REQ-006 we  input  1  register write strobe.
REQ-007 addr  input  CH_BITS+2  {channel, reg}: reg 0 LOAD, 1 CTRL, 2 COUNT (read-only), 3 STATUS.
REQ-008 wdata  input  32  write data; bits above WIDTH ignored for LOAD.
REQ-009 rdata  output  32  registered read data for addr, zero-extended.
REQ-010 cnt_out  output  CHANNELS  per-channel output (event pulse or square wave).
REQ-011 irq  output  1  OR of all enabled pending status bits.

Function
REQ-012 Per channel: LOAD (WIDTH), COUNT (WIDTH), CTRL (mode[1:0], irq_en[2]), STATUS pending bit.
REQ-013 Modes: 00 stop, 01 one-shot, 10 periodic, 11 square.
REQ-014 CTRL write with mode!=00 copies LOAD to COUNT same edge and clears cnt_out of that channel.
REQ-015 Running channel on tick_en: COUNT decrements by 1; tick while COUNT<=1 is a terminal event.
REQ-016 One-shot terminal event: COUNT=0, cnt_out goes high and holds, mode returns to 00.
REQ-017 Periodic terminal event: COUNT reloads LOAD, cnt_out high exactly one cycle.
REQ-018 Square terminal event: COUNT reloads LOAD, cnt_out toggles.
REQ-019 Every terminal event sets STATUS pending; STATUS write with wdata[0]=1 clears it.
REQ-020 Mode 00: COUNT, cnt_out frozen; tick_en ignored.
REQ-021 LOAD write while running affects the next reload only; current COUNT is unchanged.
REQ-022 CTRL write and tick_en in same cycle: write wins, tick discarded.
REQ-023 STATUS clear and terminal event in same cycle: event wins, pending stays 1.
REQ-024 Writes to COUNT register ignored; reads of any register valid one cycle after addr.
REQ-025 Channels fully independent; no cross-channel interaction except irq OR.

Reset
REQ-026 rst low at a clock edge: all LOAD, COUNT, CTRL, STATUS, cnt_out, rdata, irq become 0.
REQ-027 Reset mid-count aborts the channel; no terminal event or pending bit results.
REQ-028 Writes and ticks during reset are ignored.

Configuration
REQ-029 Macro TIMER_BANK_IRQ_EN defined: STATUS, irq_en and irq behave per REQ-011, REQ-019, REQ-023.
REQ-030 Macro absent: no STATUS/irq_en storage, STATUS reads 0, irq tied 0; counting unchanged.

Verification
REQ-031 LOAD=3, CTRL=01, tick every cycle -> cnt_out rises on 3rd tick, COUNT=0, CTRL mode reads 00.
REQ-032 LOAD=4, CTRL=10, tick every cycle -> cnt_out one-cycle pulse every 4 ticks, COUNT sequence 4,3,2,1,4.
REQ-033 LOAD=2, CTRL=11, tick every 5 cycles -> cnt_out toggles every 10 cycles, 50% duty.
REQ-034 CTRL=06 (periodic, irq_en), LOAD=1 -> irq=1 after first tick; STATUS clear coincident with next event leaves irq=1.
REQ-035 Channel 2 running at COUNT=7, rst low one cycle -> all registers read 0, cnt_out=0, no irq.
REQ-036 CH_BITS=3, WIDTH=8, LOAD write 0x1FF on channel 7 -> LOAD reads 0xFF, channels 0-6 unaffected.
